// File: rtl/clk_divider_pkg.sv
// Shared board constants and width helper for the clock divider slice.
package clk_divider_pkg;

  localparam int unsigned BOARD_CLK_FREQ_HZ = 32'd100_000_000;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n > 32'd1) ? $clog2(n) : 32'd1;
    return w;
  endfunction

endpackage

// File: rtl/clk_divider_tc_counter.sv
// Modulo-N counter with a registered terminal-count flag (o_tc is high while
// o_cnt == N-1, i.e. a one-cycle pulse per wrap when i_en is held high).
module tc_counter
  import clk_divider_pkg::*;
#(
  parameter int unsigned N = 32'd4,
  parameter int unsigned W = cnt_width(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  if (N < 32'd1) begin : g_bad_modulus
    $error("tc_counter: modulus N must be >= 1");
  end

  localparam logic [W-1:0] LAST = W'(N - 32'd1);

  logic [W-1:0] r_cnt;
  logic         r_tc;
  logic [W-1:0] w_cnt_nxt;
  logic         w_tc_nxt;

  // Next count wraps to zero from the terminal value, so it never exceeds N-1.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_en) begin
      if (r_tc) begin
        w_cnt_nxt = {W{1'b0}};
      end else begin
        w_cnt_nxt = r_cnt + W'(1);
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
    w_tc_nxt = (w_cnt_nxt == LAST);
  end

  // Count and terminal flag registers; for N == 1 the flag is set out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {W{1'b0}};
      r_tc  <= (LAST == {W{1'b0}});
    end else begin
      r_cnt <= w_cnt_nxt;
      r_tc  <= w_tc_nxt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = r_tc;

endmodule

// File: rtl/clk_divider.sv
// Divides clk down to a 50% duty square wave on led; led is a data signal,
// never to be used as a clock downstream.
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = BOARD_CLK_FREQ_HZ,
  parameter int unsigned OUT_FREQ_HZ = 32'd1,
  parameter int unsigned HALF_PERIOD = CLK_FREQ_HZ / (32'd2 * OUT_FREQ_HZ)
) (
  input  logic clk,
  input  logic rst,
  output logic led
);

  if (HALF_PERIOD < 32'd1) begin : g_bad_half_period
    $error("clk_divider: HALF_PERIOD must be >= 1");
  end

  localparam int unsigned      CNT_W = cnt_width(HALF_PERIOD);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(HALF_PERIOD - 32'd1);

  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;
  logic             w_toggle;
  logic             r_led;

  tc_counter #(
    .N (HALF_PERIOD),
    .W (CNT_W)
  ) u_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (1'b1),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  // Toggle only when the registered flag and the count agree on the terminal value.
  assign w_toggle = w_tc & (w_cnt == LAST);

  // LED level register; reset wins over any toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= 1'b0;
    end else if (w_toggle) begin
      r_led <= ~r_led;
    end else begin
      r_led <= r_led;
    end
  end

  assign led = r_led;

endmodule

// File: tb/tb_clk_divider.sv
// Scoreboard bench: four divider instances (HALF_PERIOD 4, 1, 5 and a scaled
// 1000 Hz / 1 Hz build) checked every edge against an edge-count model.
module tb_clk_divider;

  typedef struct {
    int   id;
    logic led;
    int   cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic [3:0]  rst = 4'hF;
  logic [3:0]  led;
  logic [31:0] cnt_obs [4];

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];
  exp_t ce;
  int   k  [4] = '{0, 0, 0, 0};
  int   hp [4] = '{4, 1, 5, 500};

  always #5 clk = ~clk;

  clk_divider #(.HALF_PERIOD(4)) u_d4 (.clk(clk), .rst(rst[0]), .led(led[0]));
  clk_divider #(.HALF_PERIOD(1)) u_d1 (.clk(clk), .rst(rst[1]), .led(led[1]));
  clk_divider #(.HALF_PERIOD(5)) u_d5 (.clk(clk), .rst(rst[2]), .led(led[2]));
  clk_divider #(.CLK_FREQ_HZ(1000), .OUT_FREQ_HZ(1)) u_ds (.clk(clk), .rst(rst[3]), .led(led[3]));

  assign cnt_obs[0] = 32'(u_d4.w_cnt);
  assign cnt_obs[1] = 32'(u_d1.w_cnt);
  assign cnt_obs[2] = 32'(u_d5.w_cnt);
  assign cnt_obs[3] = 32'(u_ds.w_cnt);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive rst for the next edge, push the expected post-edge state, wait past the edge.
  task automatic step(input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) k[i] = 0;
      else      k[i] = k[i] + 1;
      e.id  = i;
      e.led = (((k[i] / hp[i]) % 2) == 1);
      e.cnt = k[i] % hp[i];
      sb.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    while (sb.size() != 0) begin
      ce = sb.pop_front();
      check_eq($sformatf("led[hp=%0d]", hp[ce.id]), 32'(led[ce.id]), 32'(ce.led));
      check_eq($sformatf("cnt[hp=%0d]", hp[ce.id]), cnt_obs[ce.id], 32'(ce.cnt));
    end
  end

  initial begin
    logic prev;
    int   rises;
    int   highs;
    prev  = 1'b0;
    rises = 0;
    highs = 0;

    for (int i = 0; i < 5; i++) step(4'hF);

    for (int i = 0; i < 80; i++) begin
      step(4'h0);
      if (led[0] && !prev) rises++;
      if (led[0]) highs++;
      prev = led[0];
    end
    check_eq("hp4_rises_10_periods", 32'(rises), 32'd10);
    check_eq("hp4_high_cycles", 32'(highs), 32'd40);

    for (int i = 0; i < 22; i++) step(4'h0);
    check_eq("pre_rst_led", 32'(led[0]), 32'd1);
    check_eq("pre_rst_cnt", cnt_obs[0], 32'd2);

    step(4'h1);
    check_eq("mid_rst_led", 32'(led[0]), 32'd0);
    check_eq("mid_rst_cnt", cnt_obs[0], 32'd0);

    for (int i = 0; i < 520; i++) step(4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
